// File: rtl/rom_access_arbiter.sv
// Front-end for a single async-read / sync-write memory: round-robin readers,
// one always-accepted writer, and a whole-memory fill sequencer.
module rom_access_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned N_REQ = 2,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ*AW-1:0]   i_addr,
  output logic [N_REQ-1:0]      o_gnt,
  output logic [N_REQ-1:0]      o_rvalid,
  output logic [WIDTH-1:0]      o_rdata,
  input  logic                  i_wr_req,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  output logic                  o_wr_ack,
  input  logic                  i_clear_start,
  input  logic [WIDTH-1:0]      i_fill,
  output logic                  o_clear_busy,
  output logic                  o_clear_done,
  output logic [AW-1:0]         o_mem_rd_addr,
  input  logic [WIDTH-1:0]      i_mem_dout,
  output logic                  o_mem_wr_en,
  output logic [AW-1:0]         o_mem_wr_addr,
  output logic [WIDTH-1:0]      o_mem_din
);

  localparam int unsigned RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [RW-1:0]    rr_last_q, rr_last_d;
  logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
  logic [N_REQ-1:0] rvalid_q, rvalid_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             clear_done_q, clear_done_d;

  logic [N_REQ-1:0] gnt_c;
  logic [RW-1:0]    win_c;
  logic             found_c;
  logic [RW-1:0]    idx_c;

  // Round-robin search starting just after the last winner.
  always_comb begin
    gnt_c   = '0;
    win_c   = '0;
    found_c = 1'b0;
    idx_c   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx_c = RW'((32'(rr_last_q) + 32'd1 + i) % N_REQ);
      if (!found_c && i_req[idx_c]) begin
        found_c = 1'b1;
        win_c   = idx_c;
      end
    end
    if (found_c) gnt_c[win_c] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    rr_last_d     = rr_last_q;
    clr_cnt_d     = clr_cnt_q;
    rvalid_d      = '0;
    rdata_d       = rdata_q;
    clear_done_d  = 1'b0;
    o_gnt         = '0;
    o_wr_ack      = 1'b0;
    o_mem_rd_addr = '0;
    o_mem_wr_en   = 1'b0;
    o_mem_wr_addr = '0;
    o_mem_din     = '0;

    case (state_q)
      S_IDLE: begin
        o_gnt = gnt_c;
        if (found_c) begin
          o_mem_rd_addr = i_addr[win_c*AW +: AW];
          rvalid_d      = gnt_c;
          rdata_d       = i_mem_dout;
          rr_last_d     = win_c;
        end
        if (i_wr_req) begin
          o_wr_ack      = 1'b1;
          o_mem_wr_en   = 1'b1;
          o_mem_wr_addr = i_wr_addr;
          o_mem_din     = i_wr_data;
        end
        if (i_clear_start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        // Readers and writer stall; the sequencer owns the write port.
        o_mem_wr_en   = 1'b1;
        o_mem_wr_addr = clr_cnt_q;
        o_mem_din     = i_fill;
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          state_d      = S_IDLE;
          clr_cnt_d    = '0;
          clear_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      rr_last_q    <= RW'(N_REQ - 1);
      clr_cnt_q    <= '0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      clr_cnt_q    <= clr_cnt_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign o_rvalid     = rvalid_q;
  assign o_rdata      = rdata_q;
  assign o_clear_done = clear_done_q;
  assign o_clear_busy = (state_q == S_CLEAR);

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Self-checking bench: behavioural arbiter/memory model plus directed literal checks
// and a randomized phase.
module tb_rom_access_arbiter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 12;
  localparam int N_REQ = 2;
  localparam int AW    = 4;

  logic              clk, rst_n;
  logic [N_REQ-1:0]  req;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ-1:0]  gnt, rvalid;
  logic [WIDTH-1:0]  rdata;
  logic              wr_req;
  logic [AW-1:0]     wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              wr_ack;
  logic              clear_start;
  logic [WIDTH-1:0]  fill;
  logic              busy, done;
  logic [AW-1:0]     rd_addr;
  logic [WIDTH-1:0]  mem_dout;
  logic              wr_en;
  logic [AW-1:0]     mem_wr_addr;
  logic [WIDTH-1:0]  din;

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];

  int passed = 0;
  int total  = 0;

  // Model state
  bit               m_clearing;
  int               m_cnt;
  int               m_last;
  logic [N_REQ-1:0] m_rvalid;
  logic [WIDTH-1:0] m_rdata;
  bit               m_done;
  logic [N_REQ-1:0] m_gnt;

  rom_access_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N_REQ(N_REQ)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req(req), .i_addr(addr), .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
    .i_clear_start(clear_start), .i_fill(fill), .o_clear_busy(busy), .o_clear_done(done),
    .o_mem_rd_addr(rd_addr), .i_mem_dout(mem_dout), .o_mem_wr_en(wr_en),
    .o_mem_wr_addr(mem_wr_addr), .o_mem_din(din)
  );

  assign mem_dout = (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  function automatic void model_reset();
    m_clearing = 0; m_cnt = 0; m_last = N_REQ - 1;
    m_rvalid = '0; m_rdata = '0; m_done = 0; m_gnt = '0;
  endfunction

  // One clock cycle: check combinational outputs, clock, update model, check registers.
  task automatic tick();
    int w, k;
    logic [AW-1:0] era, ewa, cwa;
    logic [WIDTH-1:0] ed, cd, rd_old;
    logic ewe, eack, cwe, cs;
    #1;
    w = -1; m_gnt = '0; era = '0;
    if (!m_clearing)
      for (int i = 0; i < N_REQ; i++) begin
        k = (m_last + 1 + i) % N_REQ;
        if (w < 0 && req[k]) w = k;
      end
    if (w >= 0) begin m_gnt[w] = 1'b1; era = addr[w*AW +: AW]; end
    if (m_clearing) begin
      ewe = 1; eack = 0; ewa = AW'(m_cnt); ed = fill;
    end else begin
      ewe = wr_req; eack = wr_req;
      ewa = wr_req ? wr_addr : '0;
      ed  = wr_req ? wr_data : '0;
    end
    chk("gnt", gnt, m_gnt);
    chk("rd_addr", rd_addr, era);
    chk("wr_ack", wr_ack, eack);
    chk("wr_en", wr_en, ewe);
    chk("wr_addr", mem_wr_addr, ewa);
    chk("din", din, ed);
    chk("busy", busy, m_clearing);
    cwe = wr_en; cwa = mem_wr_addr; cd = din; cs = clear_start;
    rd_old = ref_mem[era];
    @(posedge clk);
    #1;
    if (cwe && int'(cwa) < DEPTH) mem[cwa] = cd;
    m_rvalid = m_gnt;
    if (w >= 0) begin m_rdata = rd_old; m_last = w; end
    if (ewe) ref_mem[ewa] = ed;
    if (m_clearing) begin
      m_cnt++;
      if (m_cnt == DEPTH) begin m_clearing = 0; m_cnt = 0; m_done = 1; end
      else m_done = 0;
    end else begin
      m_done = 0;
      if (cs) m_clearing = 1;
    end
    chk("rvalid", rvalid, m_rvalid);
    chk("done", done, m_done);
    if (m_rvalid != 0) chk("rdata", rdata, m_rdata);
  endtask

  task automatic zero_inputs();
    req = '0; addr = '0; wr_req = 0; wr_addr = '0; wr_data = '0;
    clear_start = 0; fill = '0;
  endtask

  task automatic do_reset();
    zero_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);     chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0); chk("rst_wr_ack", wr_ack, 0);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_rd_addr", rd_addr, 0); chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", mem_wr_addr, 0); chk("rst_din", din, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nb;
    bit seen_done;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = WIDTH'(8'h40 + i);
      ref_mem[i] = mem[i];
    end
    mem[5] = 8'hA5; ref_mem[5] = 8'hA5;
    rst_n = 1'b1;
    zero_inputs();
    model_reset();
    @(posedge clk);
    do_reset();

    // Single read, one-cycle latency
    req = 2'b01; addr[0 +: AW] = 4'd5;
    #1 chk("t1_gnt", gnt, 2'b01);
    tick();
    chk("t1_rvalid", rvalid, 2'b01);
    chk("t1_rdata", rdata, 8'hA5);

    // Round-robin alternation from reset
    do_reset();
    req = 2'b11; addr[0 +: AW] = 4'd1; addr[AW +: AW] = 4'd2;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t2_gnt", gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk("t2_rvalid", rvalid, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("t2_rdata", rdata, (i % 2 == 0) ? 8'h41 : 8'h42);
    end

    // Same-cycle read and write returns the old word
    req = 2'b01; addr[0 +: AW] = 4'd9;
    wr_req = 1; wr_addr = 4'd9; wr_data = 8'h3C;
    tick();
    chk("t3_old", rdata, 8'h49);
    wr_req = 0;
    tick();
    chk("t3_new", rdata, 8'h3C);
    req = '0;
    tick();

    // Full fill, requester stalled, restart attempt ignored at cnt=2
    fill = 8'hFF; clear_start = 1;
    tick();
    clear_start = 0; req = 2'b01; addr[0 +: AW] = 4'd3;
    nb = 0; seen_done = 0;
    for (int c = 0; c < DEPTH + 4; c++) begin
      clear_start = (c == 2);
      #1;
      if (busy) begin
        chk("t4_gnt", gnt, 0);
        chk("t4_addr", mem_wr_addr, c);
        nb++;
      end else if (!seen_done) begin
        chk("t4_done", done, 1);
        seen_done = 1;
      end
      tick();
    end
    chk("t4_busy_cycles", nb, DEPTH);
    for (int i = 0; i < DEPTH; i++) chk("t4_mem", mem[i], 8'hFF);

    // Reset in the middle of a fill
    req = '0; fill = 8'h55; clear_start = 1;
    tick();
    clear_start = 0;
    repeat (3) tick();
    #1 chk("t6_cnt", mem_wr_addr, 3);
    do_reset();
    tick();
    chk("t6_no_done", done, 0);
    chk("t6_idle", busy, 0);
    chk("t6_partial", mem[3], 8'hFF);

    // Randomized traffic; requests held until granted
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < N_REQ; k++)
        if (!req[k] || m_gnt[k]) begin
          req[k] = ($urandom % 3) != 0;
          addr[k*AW +: AW] = AW'($urandom % DEPTH);
        end
      wr_req = ($urandom % 3) == 0;
      wr_addr = AW'($urandom % DEPTH);
      wr_data = WIDTH'($urandom);
      clear_start = ($urandom % 64) == 0;
      fill = WIDTH'($urandom);
      tick();
    end
    zero_inputs();
    for (int n = 0; n < DEPTH + 2; n++) tick();
    for (int i = 0; i < DEPTH; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
